disp2depth_pipe_ctrl: RTL

DISP2DEPTH_PIPE_CTRL -- requirements
Module: disp2depth_pipe_ctrl

---
 rtl/disp2depth_pipe_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/disp2depth_pipe_ctrl.sv
// Flow control wrapper around an external disparity-to-depth pipeline: sideband delay line,
// first-word fall-through output FIFO, invalid-disparity marking and per-frame zero count.
module disp2depth_pipe_ctrl #(
    parameter int DISP_WIDTH  = 8,
    parameter int DEPTH_WIDTH = 16,
    parameter int PIPE_LAT    = 4,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DISP_WIDTH-1:0]  s_disp,
    input  logic                   s_sof,
    input  logic                   s_eol,
    output logic                   o_aclken,
    output logic [DISP_WIDTH-1:0]  o_pipe_din,
    input  logic [DEPTH_WIDTH-1:0] i_pipe_dout,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DEPTH_WIDTH-1:0] m_depth,
    output logic                   m_sof,
    output logic                   m_eol,
    output logic                   m_inval,
    output logic [15:0]            o_zero_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DEPTH_WIDTH + 3;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic                accept;
    logic                push;
    logic                pop;
    logic [CW-1:0]       fifo_count;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [EW-1:0]       mem [FIFO_DEPTH];
    logic [EW-1:0]       push_entry;
    logic [EW-1:0]       head;
    logic [DEPTH_WIDTH-1:0] push_depth;
    logic [PIPE_LAT-1:0] vld_p;
    logic [PIPE_LAT-1:0] sof_p;
    logic [PIPE_LAT-1:0] eol_p;
    logic [PIPE_LAT-1:0] zero_p;

    assign o_aclken   = (fifo_count < CW'(FIFO_DEPTH));
    assign s_ready    = o_aclken;
    assign accept     = s_valid & s_ready;
    assign o_pipe_din = s_disp;

    // Sideband delay line: advances only with the external pipeline's clock enable
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p  <= '0;
            sof_p  <= '0;
            eol_p  <= '0;
            zero_p <= '0;
        end else if (o_aclken) begin
            for (int i = PIPE_LAT - 1; i > 0; i--) begin
                vld_p[i]  <= vld_p[i-1];
                sof_p[i]  <= sof_p[i-1];
                eol_p[i]  <= eol_p[i-1];
                zero_p[i] <= zero_p[i-1];
            end
            vld_p[0]  <= accept;
            sof_p[0]  <= s_sof;
            eol_p[0]  <= s_eol;
            zero_p[0] <= (s_disp == '0);
        end
    end

    // Tail of the delay line describes i_pipe_dout this cycle
    assign push       = o_aclken & vld_p[PIPE_LAT-1];
    assign pop        = m_valid & m_ready;
    assign push_depth = zero_p[PIPE_LAT-1] ? '1 : i_pipe_dout;
    assign push_entry = {push_depth, sof_p[PIPE_LAT-1], eol_p[PIPE_LAT-1], zero_p[PIPE_LAT-1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    // Head is masked while empty so nothing stale ever shows on m_*
    assign head    = mem[rd_ptr];
    assign m_valid = (fifo_count != '0);
    assign m_depth = m_valid ? head[EW-1:3] : '0;
    assign m_sof   = m_valid & head[2];
    assign m_eol   = m_valid & head[1];
    assign m_inval = m_valid & head[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            o_zero_cnt <= '0;
        end else if (accept) begin
            if (s_sof)
                o_zero_cnt <= (s_disp == '0) ? 16'd1 : 16'd0;
            else if (s_disp == '0)
                o_zero_cnt <= sat_inc(o_zero_cnt);
        end
    end

endmodule
